// File: rtl/disp_hist.sv
// Four-digit capture history shown on a multiplexed, active-low 7-segment display.
// The newest captured digit sits in slot 0; slots that have never been filled show blank.
module disp_hist #(
    parameter int unsigned DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dato,
    input  logic       cap,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       lleno
);

    localparam logic [15:0] CntMax = 16'(DIV - 1);

    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] h_q;
    logic [3:0]      v_q;
    logic [3:0]      an_d;
    logic [6:0]      seg_d;
    logic [3:0]      cur;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h06;  // 10..15 render as 'E'
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        cur   = h_q[idx_q];
        an_d  = ~(4'b0001 << idx_q);
        seg_d = v_q[idx_q] ? decode(cur) : 7'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            lleno <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an    <= an_d;
            seg   <= seg_d;
            lleno <= &v_q;
            if (cap) begin
                // Oldest entry falls off the top; a valid 1 enters with the new digit.
                h_q <= {h_q[2:0], dato};
                v_q <= {v_q[2:0], 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_disp_hist.sv
// Bench for disp_hist: directed steps plus random captures, checked against a
// queue-based model of the history and an arithmetic model of the scan position.
module tb_disp_hist;

    localparam int DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk;
    logic       rst;
    logic [3:0] dato;
    logic       cap;
    logic [3:0] an;
    logic [6:0] seg;
    logic       lleno;

    int errors = 0;
    int checks = 0;
    int n      = 0;          // rising edges since reset release
    logic [3:0] hist [$];    // newest first, at most four entries

    disp_hist #(.DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .dato (dato),
        .cap  (cap),
        .an   (an),
        .seg  (seg),
        .lleno(lleno)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] s;
        if (d > 4'd9) s = 7'h06;
        else          s = SEG_TAB[d];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Asynchronous reset pulse starting between edges, released at the next falling edge.
    task automatic do_reset();
        cap  = 1'b1;
        dato = 4'd9;
        rst  = 1'b0;
        #1;
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_lleno", 32'(lleno), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cap = 1'b0;
        hist.delete();
        n = 0;
    endtask

    task automatic tick(input logic c, input logic [3:0] d);
        int         idx;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_ll;
        idx       = (n / DIV) % 4;
        e_an      = 4'b1111;
        e_an[idx] = 1'b0;
        e_seg     = (idx < hist.size()) ? seg_ref(hist[idx]) : 7'h7F;
        e_ll      = (hist.size() == 4);
        cap  = c;
        dato = d;
        @(posedge clk);
        if (c) begin
            hist.push_front(d);
            if (hist.size() > 4) void'(hist.pop_back());
        end
        n++;
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("lleno", 32'(lleno), 32'(e_ll));
        chk("onehot", 32'($countones(~an)), 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        cap  = 1'b0;
        dato = 4'd0;
        #2;
        do_reset();

        // First edge after release: slot 0 driven, blank.
        tick(1'b0, 4'd0);

        // Single capture of 2, then a few full scans.
        tick(1'b1, 4'd2);
        for (int i = 0; i < 20; i++) tick(1'b0, 4'd0);

        // Burst 2,1,5,4,3 leaves 3,4,5,1 and fills all slots.
        tick(1'b1, 4'd2);
        tick(1'b1, 4'd1);
        tick(1'b1, 4'd5);
        tick(1'b1, 4'd4);
        tick(1'b1, 4'd3);
        for (int i = 0; i < 20; i++) tick(1'b0, 4'd0);
        chk("burst_full", 32'(lleno), 32'd1);

        // Mid-operation reset discards history and restarts the scan.
        do_reset();
        for (int i = 0; i < 18; i++) tick(1'b0, 4'd0);

        // Out-of-range digit shows E; dato changes without cap are ignored.
        tick(1'b1, 4'd12);
        for (int i = 0; i < 20; i++) tick(1'b0, 4'($urandom_range(0, 15)));

        // Random captures with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else tick(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_hist.md
DISP_HIST -- requirements
Module: disp_hist

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning the number of clk cycles per display scan step; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port dato  input  4  digit from the upstream sequence FSM's sal output, sampled only when cap=1.
REQ-005 SHALL have port cap  input  1  capture strobe; one digit captured per clk cycle with cap=1.
REQ-006 SHALL have port an  output  4  digit anode enables, active-low one-hot, registered.
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port lleno  output  1  high when all four history slots hold captured digits, registered.

Function
REQ-009 SHALL hold a 4-entry history h0..h3 (4 bits each) plus valid flags v0..v3; h0 is the newest.
REQ-010 SHALL, on a rising clk edge with cap=1, shift h2->h3, h1->h2, h0->h1, dato->h0 and v2->v3, v1->v2, v0->v1, 1->v0, all in the same cycle.
REQ-011 SHALL leave history and valid flags unchanged on cycles with cap=0.
REQ-012 SHALL keep capturing with cap=1 held on consecutive cycles, one shift per cycle; the oldest entry h3 is discarded.
REQ-013 SHALL run a tick counter cnt 0..DIV-1 incrementing every clk; at DIV-1 it wraps to 0 and the scan index idx (2 bits) advances 0->1->2->3->0.
REQ-014 SHALL run the scan counter independently of cap; capture and scan advance in the same cycle are both applied.
REQ-015 SHALL register an as the active-low one-hot of idx (idx=0 -> 4'b1110, idx=3 -> 4'b0111) and seg as the decode of h[idx], both with one clk cycle of latency from idx/history.
REQ-016 SHALL decode h (active-low gfedcba) as: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-017 SHALL display 10..15 as the letter E, 7'h06.
REQ-018 SHALL display a blank digit, 7'h7F, for any slot whose valid flag is 0, while still driving its anode.
REQ-019 SHALL register lleno = v0&v1&v2&v3, with one cycle of latency after the capture that sets v3.
REQ-020 SHALL never drive more than one anode low in any cycle.

Reset
REQ-021 SHALL, while rst=0 and independent of clk, force h0..h3=0, v0..v3=0, cnt=0, idx=0, an=4'b1111, seg=7'h7F, lleno=0.
REQ-022 SHALL ignore cap while rst=0 and resume at the first rising clk edge after rst returns to 1, with idx=0.
REQ-023 SHALL discard all history when rst asserts mid-scan or mid-capture burst; no partial shift survives.

Verification (DIV=4)
REQ-024 Reset: rst=0 asynchronously between clk edges -> an=1111, seg=7F, lleno=0 immediately; 1st edge after release -> an=1110, seg=7F (blank).
REQ-025 Single capture: cap=1 one cycle with dato=2 -> slot 0 shows seg=24 when an=1110; slots 1..3 show 7F; lleno=0.
REQ-026 Burst: cap held 5 cycles with dato 2,1,5,4,3 -> h0..h3=3,4,5,1; scan shows 30,19,12,79 on an=1110,1101,1011,0111; lleno=1.
REQ-027 Scan timing: no captures -> an changes exactly every 4 clk cycles, sequence 1110,1101,1011,0111,1110; never two zeros.
REQ-028 Out of range: capture dato=12 -> its slot shows seg=06; cap=0 with dato toggling -> history unchanged.
REQ-029 Mid-operation reset: after REQ-026 state, pulse rst=0 for one half-cycle -> all slots blank, lleno=0, scan restarts at an=1110.
